// File: rtl/video_pkg.sv
// Shared definitions for the video pattern source: standard timing sets,
// pattern codes, colour constants and the RGB565 packer.
package video_pkg;

  localparam int CNT_W = 12;

  typedef struct packed {
    int h_act;
    int h_fp;
    int h_sync;
    int h_bp;
    int v_act;
    int v_fp;
    int v_sync;
    int v_bp;
  } timing_t;

  localparam timing_t TIMING_720P  = '{1280, 110, 40, 220, 720, 5, 5, 20};
  localparam timing_t TIMING_1080P = '{1920, 88, 44, 148, 1080, 4, 5, 36};
  localparam timing_t TIMING_480P  = '{720, 16, 62, 60, 480, 9, 6, 30};

  typedef enum logic [2:0] {
    PAT_BARS    = 3'd0,
    PAT_GRAY    = 3'd1,
    PAT_CHECKER = 3'd2,
    PAT_LINE    = 3'd3,
    PAT_SOLID   = 3'd4,
    PAT_XHATCH  = 3'd5
  } pattern_e;

  localparam logic [23:0] RGB_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] RGB_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] RGB_CYAN    = 24'h00FFFF;
  localparam logic [23:0] RGB_GREEN   = 24'h00FF00;
  localparam logic [23:0] RGB_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] RGB_RED     = 24'hFF0000;
  localparam logic [23:0] RGB_BLUE    = 24'h0000FF;
  localparam logic [23:0] RGB_BLACK   = 24'h000000;

  function automatic logic [15:0] pack_rgb565(input logic [23:0] rgb);
    return {rgb[23:19], rgb[15:10], rgb[7:3]};
  endfunction

endpackage

// File: rtl/video_pattern_gen_if.sv
// Control inputs and timed video outputs of the pattern source.
interface video_pattern_gen_if;
  import video_pkg::*;

  // de_re is a read request one clock ahead of de_out; de_out qualifies
  // pout/x_out/y_out. There is no backpressure: a sink must take every pixel
  // presented while de_out is high.
  logic             en;
  logic [2:0]       mode;
  logic [23:0]      fixed_rgb;
  logic             vs_out;
  logic             hs_out;
  logic             de_out;
  logic             de_re;
  logic             frame_start;
  logic [CNT_W-1:0] x_out;
  logic [CNT_W-1:0] y_out;
  logic [23:0]      pout;
  logic [CNT_W-1:0] frame_cnt;

  modport master (
    input  en, mode, fixed_rgb,
    output vs_out, hs_out, de_out, de_re, frame_start, x_out, y_out, pout, frame_cnt
  );

  modport slave (
    output en, mode, fixed_rgb,
    input  vs_out, hs_out, de_out, de_re, frame_start, x_out, y_out, pout, frame_cnt
  );

endinterface

// File: rtl/video_timing_core.sv
// Raster counters plus the first pipeline stage (active flag, x/y, sync flags)
// and the frame-boundary strobe.
module video_timing_core
  import video_pkg::*;
#(
  parameter int H_ACT  = TIMING_720P.h_act,
  parameter int H_FP   = TIMING_720P.h_fp,
  parameter int H_SYNC = TIMING_720P.h_sync,
  parameter int H_BP   = TIMING_720P.h_bp,
  parameter int V_ACT  = TIMING_720P.v_act,
  parameter int V_FP   = TIMING_720P.v_fp,
  parameter int V_SYNC = TIMING_720P.v_sync,
  parameter int V_BP   = TIMING_720P.v_bp
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             de_re,
  output logic             hs_act,
  output logic             vs_act,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             frame_tick
);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_ACT + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_ACT + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CNT_W-1:0] H_ACT_W  = CNT_W'(H_ACT);
  localparam logic [CNT_W-1:0] V_ACT_W  = CNT_W'(V_ACT);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACT + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACT + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACT + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACT + V_FP + V_SYNC);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_wrap;
  logic             v_wrap;
  logic             active;

  assign h_wrap     = (h_cnt == H_LAST);
  assign v_wrap     = (v_cnt == V_LAST);
  assign active     = (h_cnt < H_ACT_W) && (v_cnt < V_ACT_W);
  assign frame_tick = en && h_wrap && v_wrap;

  // x/y only follow the counters inside the active area so the pixel
  // coordinates hold their last active value through blanking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt  <= '0;
      v_cnt  <= '0;
      de_re  <= 1'b0;
      hs_act <= 1'b0;
      vs_act <= 1'b0;
      x      <= '0;
      y      <= '0;
    end else if (!en) begin
      h_cnt  <= '0;
      v_cnt  <= '0;
      de_re  <= 1'b0;
      hs_act <= 1'b0;
      vs_act <= 1'b0;
      x      <= '0;
      y      <= '0;
    end else begin
      h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
      if (h_wrap) begin
        v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
      end
      de_re  <= active;
      hs_act <= (h_cnt >= HS_START) && (h_cnt < HS_END);
      vs_act <= (v_cnt >= VS_START) && (v_cnt < VS_END);
      if (active) begin
        x <= h_cnt;
        y <= v_cnt;
      end
    end
  end

endmodule

// File: rtl/video_pattern_gen.sv
// Video timing and test-pattern source: selects one of six patterns per pixel
// and registers it with sync/DE in the second pipeline stage.
module video_pattern_gen
  import video_pkg::*;
#(
  parameter int H_ACT     = TIMING_720P.h_act,
  parameter int H_FP      = TIMING_720P.h_fp,
  parameter int H_SYNC    = TIMING_720P.h_sync,
  parameter int H_BP      = TIMING_720P.h_bp,
  parameter int V_ACT     = TIMING_720P.v_act,
  parameter int V_FP      = TIMING_720P.v_fp,
  parameter int V_SYNC    = TIMING_720P.v_sync,
  parameter int V_BP      = TIMING_720P.v_bp,
  parameter bit HS_POL    = 1'b1,
  parameter bit VS_POL    = 1'b1,
  parameter int OUT_FMT   = 0,
  parameter int LINE_STEP = 4
) (
  input logic          clk,
  input logic          rst,
  video_pattern_gen_if.master vid
);

  localparam int               BAR_W      = H_ACT / 8;
  localparam logic [CNT_W-1:0] BAR_1      = CNT_W'(BAR_W);
  localparam logic [CNT_W-1:0] BAR_2      = CNT_W'(2 * BAR_W);
  localparam logic [CNT_W-1:0] BAR_3      = CNT_W'(3 * BAR_W);
  localparam logic [CNT_W-1:0] BAR_4      = CNT_W'(4 * BAR_W);
  localparam logic [CNT_W-1:0] BAR_5      = CNT_W'(5 * BAR_W);
  localparam logic [CNT_W-1:0] BAR_6      = CNT_W'(6 * BAR_W);
  localparam logic [CNT_W-1:0] BAR_7      = CNT_W'(7 * BAR_W);
  localparam logic [CNT_W-1:0] H_LAST_ACT = CNT_W'(H_ACT - 1);
  localparam logic [CNT_W-1:0] V_LAST_ACT = CNT_W'(V_ACT - 1);

  logic             de_re;
  logic             hs_act;
  logic             vs_act;
  logic [CNT_W-1:0] x1;
  logic [CNT_W-1:0] y1;
  logic             frame_tick;

  pattern_e         mode_q;
  logic [CNT_W-1:0] line_pos;
  logic [CNT_W:0]   line_sum;
  logic [CNT_W-1:0] line_next;
  logic [CNT_W-1:0] frame_cnt;

  logic [23:0]      bar_rgb;
  logic [23:0]      pat_rgb;
  logic [23:0]      pix_fmt;

  logic             de_out;
  logic             hs_out;
  logic             vs_out;
  logic             frame_start;
  logic [CNT_W-1:0] x_out;
  logic [CNT_W-1:0] y_out;
  logic [23:0]      pout;

  video_timing_core #(
    .H_ACT (H_ACT),
    .H_FP  (H_FP),
    .H_SYNC(H_SYNC),
    .H_BP  (H_BP),
    .V_ACT (V_ACT),
    .V_FP  (V_FP),
    .V_SYNC(V_SYNC),
    .V_BP  (V_BP)
  ) u_timing (
    .clk       (clk),
    .rst       (rst),
    .en        (vid.en),
    .de_re     (de_re),
    .hs_act    (hs_act),
    .vs_act    (vs_act),
    .x         (x1),
    .y         (y1),
    .frame_tick(frame_tick)
  );

  // Moving-line position wraps modulo H_ACT; LINE_STEP is below H_ACT, so one
  // conditional subtract suffices.
  assign line_sum  = {1'b0, line_pos} + (CNT_W + 1)'(LINE_STEP);
  assign line_next = (line_sum >= (CNT_W + 1)'(H_ACT)) ?
                     CNT_W'(line_sum - (CNT_W + 1)'(H_ACT)) : line_sum[CNT_W-1:0];

  // Mode is only taken at the frame boundary so a frame never tears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q    <= PAT_BARS;
      line_pos  <= '0;
      frame_cnt <= '0;
    end else if (frame_tick) begin
      mode_q    <= pattern_e'(vid.mode);
      line_pos  <= line_next;
      frame_cnt <= frame_cnt + 1'b1;
    end
  end

  always_comb begin
    if      (x1 < BAR_1) bar_rgb = RGB_WHITE;
    else if (x1 < BAR_2) bar_rgb = RGB_YELLOW;
    else if (x1 < BAR_3) bar_rgb = RGB_CYAN;
    else if (x1 < BAR_4) bar_rgb = RGB_GREEN;
    else if (x1 < BAR_5) bar_rgb = RGB_MAGENTA;
    else if (x1 < BAR_6) bar_rgb = RGB_RED;
    else if (x1 < BAR_7) bar_rgb = RGB_BLUE;
    else                 bar_rgb = RGB_BLACK;
  end

  always_comb begin
    pat_rgb = RGB_BLACK;
    case (mode_q)
      PAT_BARS:    pat_rgb = bar_rgb;
      PAT_GRAY:    pat_rgb = {3{x1[7:0]}};
      PAT_CHECKER: if (x1[6] ^ y1[6]) pat_rgb = RGB_WHITE;
      PAT_LINE:    if (x1 == line_pos) pat_rgb = RGB_WHITE;
      PAT_SOLID:   pat_rgb = vid.fixed_rgb;
      PAT_XHATCH:  if ((x1[5:0] == 6'd0) || (y1[5:0] == 6'd0) ||
                       (x1 == H_LAST_ACT) || (y1 == V_LAST_ACT)) pat_rgb = RGB_WHITE;
      default:     pat_rgb = RGB_BLACK;
    endcase
  end

  assign pix_fmt = (OUT_FMT == 1) ? {8'h00, pack_rgb565(pat_rgb)} : pat_rgb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de_out      <= 1'b0;
      hs_out      <= ~HS_POL;
      vs_out      <= ~VS_POL;
      frame_start <= 1'b0;
      x_out       <= '0;
      y_out       <= '0;
      pout        <= '0;
    end else if (!vid.en) begin
      de_out      <= 1'b0;
      hs_out      <= ~HS_POL;
      vs_out      <= ~VS_POL;
      frame_start <= 1'b0;
      x_out       <= '0;
      y_out       <= '0;
      pout        <= '0;
    end else begin
      de_out      <= de_re;
      hs_out      <= hs_act ? HS_POL : ~HS_POL;
      vs_out      <= vs_act ? VS_POL : ~VS_POL;
      frame_start <= de_re && (x1 == '0) && (y1 == '0);
      if (de_re) begin
        x_out <= x1;
        y_out <= y1;
      end
      pout        <= de_re ? pix_fmt : 24'h000000;
    end
  end

  assign vid.de_re       = de_re;
  assign vid.de_out      = de_out;
  assign vid.hs_out      = hs_out;
  assign vid.vs_out      = vs_out;
  assign vid.frame_start = frame_start;
  assign vid.x_out       = x_out;
  assign vid.y_out       = y_out;
  assign vid.pout        = pout;
  assign vid.frame_cnt   = frame_cnt;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed bench for video_pattern_gen on a reduced raster (128x4 active,
// 134x7 total) with an RGB888 and an RGB565 instance run in lockstep.
module tb_video_pattern_gen;
  import video_pkg::*;

  localparam int H_ACT = 128, H_FP = 2, H_SYNC = 2, H_BP = 2;
  localparam int V_ACT = 4, V_FP = 1, V_SYNC = 1, V_BP = 1;
  localparam int FRAME_CLKS = 938;
  localparam int PIX = 512;
  localparam bit HS_POL = 1'b0;
  localparam bit VS_POL = 1'b1;

  logic        clk;
  logic        rst;
  logic        en;
  logic [2:0]  mode;
  logic [23:0] fixed_rgb;

  int n_checks = 0;
  int n_pass   = 0;
  int bad_x, bad_y;
  logic [23:0] bad_got, bad_exp;

  logic [23:0] cap    [V_ACT][H_ACT];
  logic [23:0] cap565 [V_ACT][H_ACT];
  logic [23:0] exp_q[$];

  logic [23:0] bars888 [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  logic [23:0] bars565 [8] = '{24'h00FFFF, 24'h00FFE0, 24'h0007FF, 24'h0007E0,
                               24'h00F81F, 24'h00F800, 24'h00001F, 24'h000000};

  video_pattern_gen_if vif ();
  video_pattern_gen_if vif565 ();

  assign vif.en           = en;
  assign vif.mode         = mode;
  assign vif.fixed_rgb    = fixed_rgb;
  assign vif565.en        = en;
  assign vif565.mode      = mode;
  assign vif565.fixed_rgb = fixed_rgb;

  video_pattern_gen #(
    .H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACT(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(HS_POL), .VS_POL(VS_POL), .OUT_FMT(0), .LINE_STEP(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .vid(vif)
  );

  video_pattern_gen #(
    .H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACT(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(HS_POL), .VS_POL(VS_POL), .OUT_FMT(1), .LINE_STEP(4)
  ) dut565 (
    .clk(clk),
    .rst(rst),
    .vid(vif565)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_frame_start();
    int cyc = 0;
    do begin
      step();
      cyc++;
    end while (!vif.frame_start && cyc < 2 * FRAME_CLKS);
    n_checks++;
    if (!vif.frame_start) $display("FAIL wait_frame_start timeout after %0d clocks", cyc);
    else n_pass++;
  endtask

  // Records one frame's active pixels; optionally changes mode/fixed_rgb
  // after switch_at pixels have been seen.
  task automatic capture_frame(input int switch_at, input logic [2:0] new_mode,
                               input logic [23:0] new_rgb);
    int n = 0;
    int cyc = 0;
    while (n < PIX && cyc < 2 * FRAME_CLKS) begin
      if (vif.de_out) begin
        if (vif.x_out < H_ACT && vif.y_out < V_ACT) begin
          cap[vif.y_out][vif.x_out]    = vif.pout;
          cap565[vif.y_out][vif.x_out] = vif565.pout;
        end
        n++;
        if (n == switch_at) begin
          mode      = new_mode;
          fixed_rgb = new_rgb;
        end
      end
      step();
      cyc++;
    end
    n_checks++;
    if (n != PIX) $display("FAIL capture_pixels got %0d want %0d", n, PIX);
    else n_pass++;
  endtask

  // scoreboard model of one RGB888 pixel
  function automatic logic [23:0] model_pix(input int m, input int x, input int y,
                                            input int lp, input logic [23:0] rgb);
    logic [7:0] g;
    g = 8'(x);
    case (m)
      0: return bars888[x / 16];
      1: return {g, g, g};
      2: return ((((x / 64) % 2) ^ ((y / 64) % 2)) != 0) ? 24'hFFFFFF : 24'h0;
      3: return (x == lp) ? 24'hFFFFFF : 24'h0;
      4: return rgb;
      5: return ((x % 64) == 0 || (y % 64) == 0 || x == H_ACT - 1 || y == V_ACT - 1) ?
                24'hFFFFFF : 24'h0;
      default: return 24'h0;
    endcase
  endfunction

  function automatic int frame_mismatches(input int m, input int lp, input logic [23:0] rgb);
    int bad = 0;
    for (int y = 0; y < V_ACT; y++) begin
      for (int x = 0; x < H_ACT; x++) begin
        if (cap[y][x] !== model_pix(m, x, y, lp, rgb)) begin
          if (bad == 0) begin
            bad_x = x; bad_y = y; bad_got = cap[y][x]; bad_exp = model_pix(m, x, y, lp, rgb);
          end
          bad++;
        end
      end
    end
    return bad;
  endfunction

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; mode = 3'd0; fixed_rgb = 24'h0;
    repeat (3) step();
    n_checks++; if (vif.de_out !== 1'b0) $display("FAIL reset_de_out got %b want 0", vif.de_out); else n_pass++;
    n_checks++; if (vif.de_re !== 1'b0) $display("FAIL reset_de_re got %b want 0", vif.de_re); else n_pass++;
    n_checks++; if (vif.frame_start !== 1'b0) $display("FAIL reset_frame_start got %b want 0", vif.frame_start); else n_pass++;
    n_checks++; if (vif.hs_out !== 1'b1) $display("FAIL reset_hs_out got %b want 1", vif.hs_out); else n_pass++;
    n_checks++; if (vif.vs_out !== 1'b0) $display("FAIL reset_vs_out got %b want 0", vif.vs_out); else n_pass++;
    n_checks++; if (vif.pout !== 24'h0) $display("FAIL reset_pout got %h want 0", vif.pout); else n_pass++;
    n_checks++; if (vif.x_out !== 12'd0 || vif.y_out !== 12'd0) $display("FAIL reset_xy got %0d,%0d want 0,0", vif.x_out, vif.y_out); else n_pass++;
    n_checks++; if (vif.frame_cnt !== 12'd0) $display("FAIL reset_frame_cnt got %0d want 0", vif.frame_cnt); else n_pass++;
  endtask

  task automatic test_startup();
    rst = 1'b0;
    step();
    n_checks++; if (vif.de_re !== 1'b1 || vif.de_out !== 1'b0) $display("FAIL start_edge1 de_re=%b de_out=%b want 1,0", vif.de_re, vif.de_out); else n_pass++;
    step();
    n_checks++; if (vif.de_out !== 1'b1 || vif.frame_start !== 1'b1) $display("FAIL start_edge2 de_out=%b frame_start=%b want 1,1", vif.de_out, vif.frame_start); else n_pass++;
    n_checks++; if (vif.x_out !== 12'd0 || vif.y_out !== 12'd0) $display("FAIL start_xy got %0d,%0d want 0,0", vif.x_out, vif.y_out); else n_pass++;
    n_checks++; if (vif.pout !== 24'hFFFFFF) $display("FAIL start_pout got %h want ffffff", vif.pout); else n_pass++;
    n_checks++; if (vif565.pout !== 24'h00FFFF) $display("FAIL start_pout565 got %h want 00ffff", vif565.pout); else n_pass++;
  endtask

  task automatic test_line_timing();
    int n = 0;
    int w = 0;
    while (vif.de_out === 1'b1 && n < 300) begin n++; step(); end
    n_checks++; if (n != H_ACT) $display("FAIL line_de_width got %0d want %0d", n, H_ACT); else n_pass++;
    n_checks++; if (vif.x_out !== 12'd127 || vif.y_out !== 12'd0) $display("FAIL blank_xy_hold got %0d,%0d want 127,0", vif.x_out, vif.y_out); else n_pass++;
    n_checks++; if (vif.pout !== 24'h0) $display("FAIL blank_pout got %h want 0", vif.pout); else n_pass++;
    n = 0;
    while (vif.hs_out !== HS_POL && n < 300) begin n++; step(); end
    n_checks++; if (n != H_FP) $display("FAIL hs_delay got %0d want %0d", n, H_FP); else n_pass++;
    while (vif.hs_out === HS_POL && w < 300) begin w++; step(); end
    n_checks++; if (w != H_SYNC) $display("FAIL hs_width got %0d want %0d", w, H_SYNC); else n_pass++;
  endtask

  task automatic test_frame_timing();
    int c = 0, de_cnt = 0, vs_cnt = 0, hs_cnt = 0, fs_cnt = 0, lag_bad = 0;
    int first_vs = -1, first_hs = -1;
    logic prev_re;
    wait_frame_start();
    prev_re = vif.de_re;
    do begin
      if (vif.de_out === 1'b1) de_cnt++;
      if (vif.vs_out === VS_POL) begin vs_cnt++; if (first_vs < 0) first_vs = c; end
      if (vif.hs_out === HS_POL) begin hs_cnt++; if (first_hs < 0) first_hs = c; end
      if (vif.frame_start === 1'b1) fs_cnt++;
      step();
      c++;
      if (vif.de_out !== prev_re) lag_bad++;
      prev_re = vif.de_re;
    end while (vif.frame_start !== 1'b1 && c < 2 * FRAME_CLKS);
    n_checks++; if (c != FRAME_CLKS) $display("FAIL frame_period got %0d want %0d", c, FRAME_CLKS); else n_pass++;
    n_checks++; if (de_cnt != PIX) $display("FAIL frame_de_count got %0d want %0d", de_cnt, PIX); else n_pass++;
    n_checks++; if (vs_cnt != 134) $display("FAIL frame_vs_count got %0d want 134", vs_cnt); else n_pass++;
    n_checks++; if (first_vs != 670) $display("FAIL frame_vs_start got %0d want 670", first_vs); else n_pass++;
    n_checks++; if (hs_cnt != 14) $display("FAIL frame_hs_count got %0d want 14", hs_cnt); else n_pass++;
    n_checks++; if (first_hs != 130) $display("FAIL frame_hs_start got %0d want 130", first_hs); else n_pass++;
    n_checks++; if (fs_cnt != 1) $display("FAIL frame_start_count got %0d want 1", fs_cnt); else n_pass++;
    n_checks++; if (lag_bad != 0) $display("FAIL de_re_lead got %0d misaligned clocks want 0", lag_bad); else n_pass++;
  endtask

  task automatic test_bars();
    int bad;
    int bad565 = 0;
    int hi_bad = 0;
    logic [23:0] e;
    wait_frame_start();
    capture_frame(0, 3'd0, 24'h0);
    bad = frame_mismatches(0, 0, 24'h0);
    n_checks++; if (bad != 0) $display("FAIL bars_frame %0d bad, first (%0d,%0d) got %h want %h", bad, bad_x, bad_y, bad_got, bad_exp); else n_pass++;
    n_checks++; if (cap[0][16] !== 24'hFFFF00) $display("FAIL bars_yellow got %h want ffff00", cap[0][16]); else n_pass++;
    n_checks++; if (cap[1][111] !== 24'h0000FF) $display("FAIL bars_blue_edge got %h want 0000ff", cap[1][111]); else n_pass++;
    n_checks++; if (cap[3][112] !== 24'h000000) $display("FAIL bars_black_edge got %h want 000000", cap[3][112]); else n_pass++;
    for (int x = 0; x < H_ACT; x++) exp_q.push_back(bars565[x / 16]);
    for (int x = 0; x < H_ACT; x++) begin
      e = exp_q.pop_front();
      if (cap565[2][x] !== e) bad565++;
    end
    n_checks++; if (bad565 != 0) $display("FAIL bars565_line %0d bad pixels want 0", bad565); else n_pass++;
    n_checks++; if (cap565[0][80] !== 24'h00F800) $display("FAIL bars565_red got %h want 00f800", cap565[0][80]); else n_pass++;
    for (int y = 0; y < V_ACT; y++)
      for (int x = 0; x < H_ACT; x++)
        if (cap565[y][x][23:16] !== 8'h00) hi_bad++;
    n_checks++; if (hi_bad != 0) $display("FAIL rgb565_upper_byte %0d nonzero want 0", hi_bad); else n_pass++;
  endtask

  task automatic test_patterns();
    int modes [4] = '{1, 5, 6, 7};
    int bad;
    for (int i = 0; i < 4; i++) begin
      mode = 3'(modes[i]);
      wait_frame_start();
      capture_frame(0, 3'd0, 24'h0);
      bad = frame_mismatches(modes[i], 0, 24'h0);
      n_checks++; if (bad != 0) $display("FAIL pattern_mode%0d %0d bad, first (%0d,%0d) got %h want %h", modes[i], bad, bad_x, bad_y, bad_got, bad_exp); else n_pass++;
    end
    n_checks++; if (cap[0][0] !== 24'h000000) $display("FAIL mode7_black got %h want 0", cap[0][0]); else n_pass++;
  endtask

  task automatic test_mode_switch();
    int bad;
    int bad565 = 0;
    mode = 3'd2;
    fixed_rgb = 24'h0;
    wait_frame_start();
    capture_frame(200, 3'd4, 24'h123456);
    bad = frame_mismatches(2, 0, 24'h0);
    n_checks++; if (bad != 0) $display("FAIL switch_keeps_checker %0d bad, first (%0d,%0d) got %h want %h", bad, bad_x, bad_y, bad_got, bad_exp); else n_pass++;
    n_checks++; if (cap[3][70] !== 24'hFFFFFF) $display("FAIL checker_white got %h want ffffff", cap[3][70]); else n_pass++;
    wait_frame_start();
    capture_frame(0, 3'd0, 24'h0);
    bad = frame_mismatches(4, 0, 24'h123456);
    n_checks++; if (bad != 0) $display("FAIL switch_solid %0d bad, first (%0d,%0d) got %h want %h", bad, bad_x, bad_y, bad_got, bad_exp); else n_pass++;
    for (int y = 0; y < V_ACT; y++)
      for (int x = 0; x < H_ACT; x++)
        if (cap565[y][x] !== 24'h0011AA) bad565++;
    n_checks++; if (bad565 != 0) $display("FAIL solid565 %0d bad want all 0011aa", bad565); else n_pass++;
  endtask

  task automatic test_moving_line();
    int bad;
    mode = 3'd3;
    do_reset();
    wait_frame_start();
    for (int f = 1; f <= 33; f++) begin
      wait_frame_start();
      n_checks++; if (vif.frame_cnt !== 12'(f)) $display("FAIL line_frame_cnt got %0d want %0d", vif.frame_cnt, f); else n_pass++;
      capture_frame(0, 3'd3, 24'h0);
      bad = frame_mismatches(3, (4 * f) % H_ACT, 24'h0);
      n_checks++; if (bad != 0) $display("FAIL line_frame%0d %0d bad, first (%0d,%0d) got %h want %h", f, bad, bad_x, bad_y, bad_got, bad_exp); else n_pass++;
      if (f == 32) begin
        n_checks++; if (cap[2][0] !== 24'hFFFFFF) $display("FAIL line_wrap got %h want ffffff", cap[2][0]); else n_pass++;
      end
    end
  endtask

  task automatic test_enable_pause();
    int cyc = 0;
    while (!(vif.de_out === 1'b1 && vif.x_out === 12'd50) && cyc < 2 * FRAME_CLKS) begin step(); cyc++; end
    n_checks++; if (vif.x_out !== 12'd50) $display("FAIL pause_find_x50 got %0d want 50", vif.x_out); else n_pass++;
    n_checks++; if (vif.frame_cnt !== 12'd34) $display("FAIL pause_frame_cnt_before got %0d want 34", vif.frame_cnt); else n_pass++;
    en = 1'b0;
    step();
    n_checks++; if (vif.de_out !== 1'b0 || vif.de_re !== 1'b0) $display("FAIL pause_de de_out=%b de_re=%b want 0,0", vif.de_out, vif.de_re); else n_pass++;
    n_checks++; if (vif.hs_out !== 1'b1 || vif.vs_out !== 1'b0) $display("FAIL pause_sync hs=%b vs=%b want 1,0", vif.hs_out, vif.vs_out); else n_pass++;
    n_checks++; if (vif.x_out !== 12'd0 || vif.pout !== 24'h0) $display("FAIL pause_x_pout x=%0d pout=%h want 0,0", vif.x_out, vif.pout); else n_pass++;
    repeat (9) step();
    n_checks++; if (vif.de_out !== 1'b0) $display("FAIL pause_hold_de got %b want 0", vif.de_out); else n_pass++;
    en = 1'b1;
    step();
    n_checks++; if (vif.de_re !== 1'b1 || vif.de_out !== 1'b0) $display("FAIL resume_edge1 de_re=%b de_out=%b want 1,0", vif.de_re, vif.de_out); else n_pass++;
    step();
    n_checks++; if (vif.de_out !== 1'b1 || vif.frame_start !== 1'b1) $display("FAIL resume_edge2 de_out=%b frame_start=%b want 1,1", vif.de_out, vif.frame_start); else n_pass++;
    n_checks++; if (vif.x_out !== 12'd0 || vif.y_out !== 12'd0) $display("FAIL resume_xy got %0d,%0d want 0,0", vif.x_out, vif.y_out); else n_pass++;
    n_checks++; if (vif.frame_cnt !== 12'd34) $display("FAIL resume_frame_cnt got %0d want 34", vif.frame_cnt); else n_pass++;
  endtask

  task automatic test_async_reset();
    repeat (30) step();
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (vif.de_out !== 1'b0 || vif.de_re !== 1'b0) $display("FAIL async_de de_out=%b de_re=%b want 0,0", vif.de_out, vif.de_re); else n_pass++;
    n_checks++; if (vif.x_out !== 12'd0 || vif.y_out !== 12'd0) $display("FAIL async_xy got %0d,%0d want 0,0", vif.x_out, vif.y_out); else n_pass++;
    n_checks++; if (vif.frame_cnt !== 12'd0) $display("FAIL async_frame_cnt got %0d want 0", vif.frame_cnt); else n_pass++;
    n_checks++; if (vif.hs_out !== 1'b1 || vif.vs_out !== 1'b0) $display("FAIL async_sync hs=%b vs=%b want 1,0", vif.hs_out, vif.vs_out); else n_pass++;
    step();
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_startup();
    test_line_timing();
    test_frame_timing();
    test_bars();
    test_patterns();
    test_mode_switch();
    test_moving_line();
    test_enable_pause();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/video_pattern_gen.md
Name: video_pattern_gen

Overview:
- Parametrised timing plus test-pattern source for the video loop.
- Generates HS, VS and DE for any CEA/VESA-style mode. Produces one of six run-time-selectable patterns (some animated), packed as RGB888 or RGB565.
- Replaces the fixed 720p sync and colour-bar pairing. Sits at the head of the loop and drives the output encoder or a frame-buffer writer.

Parameters:
- H_ACT, 1280, active pixels per line
- H_FP, 110, horizontal front porch (clocks)
- H_SYNC, 40, horizontal sync width
- H_BP, 220, horizontal back porch
- V_ACT, 720, active lines
- V_FP, 5, vertical front porch (lines)
- V_SYNC, 5, vertical sync width
- V_BP, 20, vertical back porch
- HS_POL, 1, active level of hs_out
- VS_POL, 1, active level of vs_out
- OUT_FMT, 0, 0 = RGB888 on pout[23:0]; 1 = RGB565 on pout[15:0] with pout[23:16] = 0
- LINE_STEP, 4, pixels the moving line advances per frame

Ports:
- clk, in, 1, pixel clock
- rst, in, 1, asynchronous active-high reset
- en, in, 1, run enable; low = synchronous restart
- mode, in, 3, pattern select
- fixed_rgb, in, 24, solid colour {R,G,B}
- vs_out, out, 1, vertical sync
- hs_out, out, 1, horizontal sync
- de_out, out, 1, data enable, aligned with pout
- de_re, out, 1, DE one cycle early (read request for buffers)
- frame_start, out, 1, one-cycle pulse coincident with pixel (0,0) on de_out
- x_out, out, 12, active x of current pout
- y_out, out, 12, active y of current pout
- pout, out, 24, pixel data
- frame_cnt, out, 12, completed frames, wraps at 4095

Behaviour:
- Reset state: counters 0, frame_cnt 0, mode_q 0, de_out/de_re/frame_start 0, hs_out = ~HS_POL, vs_out = ~VS_POL, pout/x_out/y_out 0.
- Counters:
  - h_cnt runs 0..H_TOTAL-1, where H_TOTAL = H_ACT+H_FP+H_SYNC+H_BP.
  - v_cnt increments when h_cnt wraps and runs 0..V_TOTAL-1.
  - Region order per line/frame: active, FP, sync, BP.
  - hs is active for H_ACT+H_FP <= h_cnt < H_ACT+H_FP+H_SYNC; vs follows the same rule on v_cnt.
- Pipeline, 2 stages:
  - Stage 1 registers active = (h_cnt<H_ACT && v_cnt<V_ACT) as de_re, plus x, y, hs, vs.
  - Stage 2 registers de_out, hs_out, vs_out, x_out, y_out and pout from stage 1.
  - de_re therefore leads de_out by exactly 1 clock.
  - hs_out, vs_out and de_out are mutually aligned.
- After rst release with en=1: de_re = 1 on the 1st edge, de_out = 1 with pixel (0,0) on the 2nd edge.
- en=0:
  - Counters cleared to 0 and stage registers loaded with reset values on the next edge.
  - On re-assertion, timing restarts exactly as after reset.
  - frame_cnt holds.
- Frame boundary (h_cnt, v_cnt wrap to 0,0):
  - mode_q <= mode.
  - frame_cnt increments.
  - line_pos <= (line_pos+LINE_STEP) mod H_ACT.
  - mode changes mid-frame take effect only at this boundary, so no tearing.
- Patterns (per active pixel at x, y):
  - 0, colour bars: 8 bars of width BAR_W = H_ACT/8, selected with a constant comparator chain (no divider). Order: white, yellow, cyan, green, magenta, red, blue, black. x >= 7*BAR_W is black.
  - 1, gray ramp: R = G = B = x[7:0].
  - 2, checkerboard: white if x[6]^y[6], else black.
  - 3, moving line: white where x == line_pos, else black.
  - 4, solid: fixed_rgb.
  - 5, crosshatch: white if x[5:0]==0, or y[5:0]==0, or x==H_ACT-1, or y==V_ACT-1, else black.
  - 6, 7: black.
- Outside active area: pout = 0, x_out and y_out hold their last active value.
- RGB565 packing: {R[7:3], G[7:2], B[7:3]}.
- frame_start = de_out && x_out==0 && y_out==0.
- Async rst mid-frame: all state returns to reset values immediately.

Decomposition:
- Shared package video_pkg holds:
  - timing-mode constant sets (720p, 1080p, 480p)
  - pattern mode encodings (PAT_BARS = 0 … PAT_XHATCH = 5)
  - colour constants
  - RGB565 pack function
- One sub-module, video_timing_core: counters, stage-1 timing registers and frame-boundary strobe.
- Pattern mux and stage 2 stay in video_pattern_gen.

Test Plan:
- Defaults, mode = 0: de_out high for 1280 clocks per line and 720 lines per frame. hs_out high for 40 clocks starting 110 clocks after DE falls. Frame period 1650*750 = 1,237,500 clocks. Pixel x = 160 has pout = 0xFFFF00.
- OUT_FMT = 1, mode = 0: x = 0 gives pout = 0x00FFFF; x = 5*160 (red) gives pout = 0x00F800; pout[23:16] = 0 always.
- Small mode (H_ACT = 16, H_FP = 2, H_SYNC = 2, H_BP = 2, V_ACT = 4, V_FP = V_SYNC = V_BP = 1): de_re rises exactly 1 clock before de_out every line. frame_start fires once per 154 clocks, with x_out = y_out = 0.
- Mode 3, LINE_STEP = 4: frame n shows white only at x = 4n mod H_ACT. After 320 frames at H_ACT = 1280 the line is back at x = 0. frame_cnt increments once per frame.
- mode switched 2 -> 4 mid-frame (fixed_rgb = 0x123456): remainder of frame stays checkerboard; every active pixel of the next frame is 0x123456.
- en low for 10 clocks mid-line, then high: outputs inactive 1 clock after en falls. de_re reasserts 1 clock after en rises, pixel (0,0) appears 1 clock later, and frame_cnt is unchanged across the pause. Async rst asserted mid-frame resets all outputs to reset values without waiting for clk.
